led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Parametrised LED pattern generator for the board LED bank. Internal prescaler divides clk into a step rate.
//  Modes: walk-down, walk-up, bounce (ping-pong) and binary count. Run-time speed select and enable/pause.
//  Drives the LED pins directly; step_tick is exported for chaining other blinking/debug logic.
// PARAMETERS
//  NUM_LEDS  8           width of LED bank (>=1)
//  TICK_DIV  20000000    clk cycles per step at speed=0 (>=1)
//  DIV_W     $clog2(TICK_DIV+1)  prescaler width (derived, do not override)
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  en         in   1         1=run, 0=pause (prescaler and pattern hold)
//  mode       in   2         00 walk-down, 01 walk-up, 10 bounce, 11 binary count
//  speed      in   2         step period = max(TICK_DIV >> speed, 1) cycles
//  led        out  NUM_LEDS  LED drive, registered
//  step_tick  out  1         1-cycle pulse on each pattern step, registered
//  dir        out  1         bounce direction: 0 toward LSB, 1 toward MSB
// BEHAVIOUR
//  Reset (rst=1 at posedge; overrides every other input): led=1<<(NUM_LEDS-1), prescaler=0,
//   step_tick=0, dir=0, mode_q=mode, speed_q=speed.
//  Prescaler: period P = max(TICK_DIV>>speed,1). While en=1 it increments each cycle; when cnt>=P-1
//   it loads 0 and the step is taken. Compare is >=, so lowering P mid-count gives a step next cycle.
//  step_tick=1 for exactly the cycle after the step edge. led/dir update on the same edge, so the new
//   pattern and step_tick are visible together.
//  en=0: prescaler, led, dir hold; step_tick=0. Resuming completes the remaining cycles of the period.
//  Mode change (mode!=mode_q, sampled every cycle regardless of en): next edge loads the start pattern
//   of the new mode, prescaler=0, dir=0, step_tick=0, mode_q=mode.
//   Start patterns: 00 and 10 -> MSB one-hot; 01 -> LSB one-hot (1); 11 -> all zeros.
//  Speed change (speed!=speed_q): no pattern reset; only P changes; speed_q updates.
//  Step actions:
//   00: rotate right (bit0 wraps to MSB).  01: rotate left (MSB wraps to bit0).
//   10: dir=0 -> shift right; if led[0] already set, set dir=1 and shift left instead.
//       dir=1 -> shift left; if led[MSB] set, set dir=0 and shift right. Ends are never held twice.
//   11: led = led+1 mod 2^NUM_LEDS (wrap all-ones -> 0).
//  NUM_LEDS=1: one-hot modes keep led=1 and dir=0; count mode toggles.
//  dir is held at 0 in every mode other than 10.
//  No combinational path from inputs to outputs.
// TESTING  (bench: NUM_LEDS=8, TICK_DIV=4)
//  1 Reset: rst=1 3 cycles, mode=00 -> led=8'h80, step_tick=0, dir=0. Release -> first step after 4 cycles.
//  2 Walk-down, speed=0, en=1: steps every 4 cycles, 80,40,20,..,01,80. step_tick asserted 1 of every 4 cycles.
//  3 Bounce: from 80: 40..01, then 02 with dir=1 on that step, .. 80 then 40 with dir=0. Period 14 steps.
//  4 Count mode: 00,01,..,FF,00 after 256 steps. speed=2 -> P=1: step_tick high every cycle.
//  5 Pause: en=0 two cycles after a step for 10 cycles -> led/cnt hold, no tick.
//    Re-enable -> next step 2 cycles later.
//  6 Mode 11->01 mid-period: next edge led=8'h01, cnt=0, then 02 four cycles later.
//    rst mid-run -> led=8'h80 next edge.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: control inputs (en/mode/speed) and LED outputs (led/step_tick/dir) of the sequencer
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 8
);
  logic                en;
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic [NUM_LEDS-1:0] led;
  logic                step_tick;
  logic                dir;
  modport master (output en, mode, speed, input led, step_tick, dir);
  modport slave (input en, mode, speed, output led, step_tick, dir);
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: prescaled LED walk/bounce/count generator; ports clk, rst, bus (en, mode, speed in; led, step_tick, dir out)
module led_pattern_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int TICK_DIV = 20000000,
  parameter int DIV_W    = $clog2(TICK_DIV + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  led_pattern_sequencer_if.slave   bus
);
  localparam logic [DIV_W-1:0]    DIV = DIV_W'(TICK_DIV);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] MSB = ONE << (NUM_LEDS - 1);
  logic [DIV_W-1:0]    cnt, per, lim;
  logic [NUM_LEDS-1:0] led_q, step_led, start_led, rotr, rotl, bnc_led;
  logic [1:0]          mode_q, speed_q;
  logic                dir_q, tick_q, step, bnc_dir, step_dir;
  assign bus.led       = led_q;
  assign bus.step_tick = tick_q;
  assign bus.dir       = dir_q;
  // Period follows the registered speed; >= compare makes a shortened period fire immediately.
  always_comb begin
    per       = DIV >> speed_q;
    lim       = (per == '0) ? '0 : per - DIV_W'(1);
    step      = bus.en && (cnt >= lim);
    rotr      = (led_q >> 1) | (led_q << (NUM_LEDS - 1));
    rotl      = (led_q << 1) | (led_q >> (NUM_LEDS - 1));
    bnc_dir   = dir_q ? !led_q[NUM_LEDS-1] : led_q[0];
    bnc_led   = (NUM_LEDS == 1) ? led_q : bnc_dir ? led_q << 1 : led_q >> 1;
    step_led  = (mode_q == 2'b00) ? rotr :
                (mode_q == 2'b01) ? rotl :
                (mode_q == 2'b10) ? bnc_led : led_q + ONE;
    step_dir  = (mode_q == 2'b10) && (NUM_LEDS > 1) && bnc_dir;
    start_led = (bus.mode == 2'b11) ? '0 : (bus.mode == 2'b01) ? ONE : MSB;
  end
  always_ff @(posedge clk) begin
    mode_q  <= bus.mode;
    speed_q <= bus.speed;
    if (rst) begin
      led_q  <= MSB;
      cnt    <= '0;
      tick_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (bus.mode != mode_q) begin
      led_q  <= start_led;
      cnt    <= '0;
      tick_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      tick_q <= step;
      if (bus.en) cnt <= step ? '0 : cnt + DIV_W'(1);
      if (step) begin
        led_q <= step_led;
        dir_q <= step_dir;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: vector table, directed corner sequences and randomized run against a position-based model
module tb_led_pattern_sequencer;
  localparam int N = 8;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  led_pattern_sequencer_if #(.NUM_LEDS(N)) bus ();
  led_pattern_sequencer #(.NUM_LEDS(N), .TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] led;
    logic       tick;
    logic       dir;
  } vec_t;
  vec_t vt[16];
  // Model: one-hot modes tracked as a bit position, count mode as an integer value,
  // prescaler as cycles elapsed in the current period.
  int m_pos, m_cval, m_e, m_mode, m_speed;
  bit m_dir, m_tick;
  function automatic logic [7:0] m_led();
    return (m_mode == 3) ? 8'(m_cval) : 8'(1 << m_pos);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    int p;
    if (rst) begin
      m_pos = N - 1; m_cval = 1 << (N - 1); m_e = 0; m_dir = 0; m_tick = 0;
      m_mode = int'(bus.mode); m_speed = int'(bus.speed);
    end else if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode);
      m_pos = (m_mode == 1) ? 0 : N - 1; m_cval = 0; m_e = 0; m_dir = 0; m_tick = 0;
      m_speed = int'(bus.speed);
    end else begin
      p = TD >> m_speed;
      if (p < 1) p = 1;
      m_tick = 0;
      if (bus.en) begin
        if (m_e >= p - 1) begin
          m_e = 0;
          m_tick = 1;
          case (m_mode)
            0: m_pos = (m_pos + N - 1) % N;
            1: m_pos = (m_pos + 1) % N;
            2: if (!m_dir) begin
                 if (m_pos == 0) begin m_dir = 1; m_pos = 1; end else m_pos--;
               end else begin
                 if (m_pos == N - 1) begin m_dir = 0; m_pos = N - 2; end else m_pos++;
               end
            default: m_cval = (m_cval + 1) % (1 << N);
          endcase
        end else m_e++;
      end
      m_speed = int'(bus.speed);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_led", 32'(bus.led), 32'(m_led()));
    chk("model_tick", 32'(bus.step_tick), 32'(m_tick));
    chk("model_dir", 32'(bus.dir), 32'(m_dir));
  endtask
  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [1:0] s);
    rst = r; bus.en = e; bus.mode = m; bus.speed = s;
  endtask
  logic [7:0] bseq[15];
  logic       bdir[15];
  initial begin
    vt[0]  = '{1, 1, 0, 0, 8'h80, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 8'h80, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 8'h80, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 8'h80, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 8'h80, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 8'h80, 0, 0};
    vt[6]  = '{0, 1, 0, 0, 8'h40, 1, 0};
    vt[7]  = '{0, 1, 0, 0, 8'h40, 0, 0};
    vt[8]  = '{0, 1, 0, 0, 8'h40, 0, 0};
    vt[9]  = '{0, 1, 0, 0, 8'h40, 0, 0};
    vt[10] = '{0, 1, 0, 0, 8'h20, 1, 0};
    vt[11] = '{0, 1, 2, 0, 8'h80, 0, 0};
    vt[12] = '{0, 1, 3, 0, 8'h00, 0, 0};
    vt[13] = '{0, 1, 3, 2, 8'h00, 0, 0};
    vt[14] = '{0, 1, 3, 2, 8'h01, 1, 0};
    vt[15] = '{0, 1, 3, 2, 8'h02, 1, 0};
    bseq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
             8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    bdir = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    drive(1, 1, 0, 0);
    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].speed);
      cyc();
      chk($sformatf("vec%0d_led", i), 32'(bus.led), 32'(vt[i].led));
      chk($sformatf("vec%0d_tick", i), 32'(bus.step_tick), 32'(vt[i].tick));
      chk($sformatf("vec%0d_dir", i), 32'(bus.dir), 32'(vt[i].dir));
    end
    for (int i = 0; i < 253; i++) cyc();
    chk("count_ff", 32'(bus.led), 32'h0ff);
    cyc();
    chk("count_wrap", 32'(bus.led), 32'h000);
    chk("count_wrap_tick", 32'(bus.step_tick), 32'h1);
    drive(0, 1, 0, 0);
    cyc();
    chk("walk_start", 32'(bus.led), 32'h080);
    for (int i = 0; i < 4; i++) cyc();
    chk("walk_step", 32'(bus.led), 32'h040);
    cyc(); cyc();
    bus.en = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pause_led", 32'(bus.led), 32'h040);
      chk("pause_tick", 32'(bus.step_tick), 32'h0);
    end
    bus.en = 1;
    cyc();
    chk("resume1_tick", 32'(bus.step_tick), 32'h0);
    cyc();
    chk("resume2_led", 32'(bus.led), 32'h020);
    chk("resume2_tick", 32'(bus.step_tick), 32'h1);
    bus.mode = 3;
    cyc();
    chk("cnt_start", 32'(bus.led), 32'h000);
    for (int i = 0; i < 6; i++) cyc();
    bus.mode = 1;
    cyc();
    chk("up_start", 32'(bus.led), 32'h001);
    chk("up_start_tick", 32'(bus.step_tick), 32'h0);
    cyc(); cyc(); cyc();
    chk("up_hold", 32'(bus.led), 32'h001);
    cyc();
    chk("up_step", 32'(bus.led), 32'h002);
    rst = 1;
    cyc();
    chk("midrst_led", 32'(bus.led), 32'h080);
    chk("midrst_tick", 32'(bus.step_tick), 32'h0);
    drive(0, 1, 2, 2);
    cyc();
    chk("bnc_start", 32'(bus.led), 32'h080);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("bnc%0d_led", i), 32'(bus.led), 32'(bseq[i]));
      chk($sformatf("bnc%0d_dir", i), 32'(bus.dir), 32'(bdir[i]));
    end
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.speed = 2'($urandom_range(0, 3));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
